rr_arbiter: RTL and testbench

RR_ARBITER -- requirements
Module: rr_arbiter

---
 rtl/rr_arbiter_pkg.sv | 18 +
 rtl/priority_encoder.sv | 33 +++
 rtl/rr_arbiter.sv | 156 +++++++++++++++
 tb/tb_rr_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rr_arbiter_pkg
// Purpose : shared definitions for the round-robin arbiter: the two-state
//           FSM encoding and the width of the grant hold counter.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package rr_arbiter_pkg;

   // Arbiter FSM: IDLE waits for requests, BUSY holds a grant.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_e;

   // Hold counter width; wide enough for the largest legal TIMEOUT (255).
   localparam int CNT_W = 8;

endpackage : rr_arbiter_pkg

// File: rtl/priority_encoder.sv
// ---------------------------------------------------------------------------
// priority_encoder
// Purpose : returns the index of the highest set bit of a vector.
// Ports   :
//   i_vec   [W-1:0]  input vector
//   o_idx   [MW-1:0] index of the highest set bit (0 when none set)
//   o_valid          at least one bit of i_vec is set
// ---------------------------------------------------------------------------
module priority_encoder #(
   parameter int W  = 8,
   parameter int MW = (W > 1) ? $clog2(W) : 1
) (
   input  logic [W-1:0]  i_vec,
   output logic [MW-1:0] o_idx,
   output logic          o_valid
);

   // Ascending scan: the last set bit visited is the highest one.
   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (i_vec[i]) begin
            o_idx   = MW'(i);
            o_valid = 1'b1;
         end else begin
            o_idx   = o_idx;
            o_valid = o_valid;
         end
      end
   end

endmodule : priority_encoder

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purpose : round-robin arbiter with a bounded grant hold. The winner is the
//           highest requesting index below the previous winner, wrapping to
//           the highest requesting index overall. A grant is held until the
//           owner strobes done, drops its request, or the hold limit expires.
// Ports   :
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset
//   req  [N-1:0] per-requester request levels
//   done         release strobe from the current owner (ignored in IDLE)
//   grant[N-1:0] registered one-hot grant, or all-zero
//   grant_id     binary index of the current owner
//   grant_valid  a grant is active
//   timeout      one-cycle pulse, coincident with the drop, on forced revoke
// ---------------------------------------------------------------------------
module rr_arbiter
   import rr_arbiter_pkg::*;
#(
   parameter int N       = 8,
   parameter int M       = $clog2(N),
   parameter int TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         done,
   output logic [N-1:0] grant,
   output logic [M-1:0] grant_id,
   output logic         grant_valid,
   output logic         timeout
);

   arb_state_e        r_state;
   logic [N-1:0]      r_grant;
   logic [M-1:0]      r_grant_id;
   logic              r_grant_valid;
   logic              r_timeout;
   logic [M-1:0]      r_last;
   logic [CNT_W-1:0]  r_cnt;

   arb_state_e        w_state_nxt;
   logic [N-1:0]      w_grant_nxt;
   logic [M-1:0]      w_grant_id_nxt;
   logic              w_grant_valid_nxt;
   logic              w_timeout_nxt;
   logic [M-1:0]      w_last_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;

   logic [N-1:0]      w_mask;
   logic [N-1:0]      w_masked;
   logic [M-1:0]      w_masked_idx;
   logic              w_masked_valid;
   logic [M-1:0]      w_full_idx;
   logic              w_full_valid;
   logic [M-1:0]      w_winner;
   logic              w_owner_req;
   logic              w_cnt_limit;

   // Only indices strictly below the previous winner are eligible first.
   assign w_mask   = (N'(1) << r_last) - N'(1);
   assign w_masked = req & w_mask;

   priority_encoder #(.W(N), .MW(M)) u_pe_masked (
      .i_vec   (w_masked),
      .o_idx   (w_masked_idx),
      .o_valid (w_masked_valid)
   );

   priority_encoder #(.W(N), .MW(M)) u_pe_full (
      .i_vec   (req),
      .o_idx   (w_full_idx),
      .o_valid (w_full_valid)
   );

   // Nothing eligible below last means wrap to the top of the request vector.
   assign w_winner    = w_masked_valid ? w_masked_idx : w_full_idx;
   assign w_owner_req = req[r_grant_id];
   assign w_cnt_limit = (r_cnt == CNT_W'(TIMEOUT - 1));

   // Next-state and next-output logic of the arbitration FSM.
   always_comb begin
      w_state_nxt       = r_state;
      w_grant_nxt       = r_grant;
      w_grant_id_nxt    = r_grant_id;
      w_grant_valid_nxt = r_grant_valid;
      w_timeout_nxt     = 1'b0;
      w_last_nxt        = r_last;
      w_cnt_nxt         = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_full_valid) begin
               w_state_nxt       = ST_BUSY;
               w_grant_nxt       = N'(1) << w_winner;
               w_grant_id_nxt    = w_winner;
               w_grant_valid_nxt = 1'b1;
               w_last_nxt        = w_winner;
               w_cnt_nxt         = '0;
            end else begin
               w_grant_nxt       = '0;
               w_grant_valid_nxt = 1'b0;
            end
         end
         ST_BUSY: begin
            // A voluntary release outranks the hold limit, so no timeout pulse.
            if (done || !w_owner_req) begin
               w_state_nxt       = ST_IDLE;
               w_grant_nxt       = '0;
               w_grant_valid_nxt = 1'b0;
               w_cnt_nxt         = '0;
            end else if (w_cnt_limit) begin
               w_state_nxt       = ST_IDLE;
               w_grant_nxt       = '0;
               w_grant_valid_nxt = 1'b0;
               w_timeout_nxt     = 1'b1;
               w_cnt_nxt         = '0;
            end else begin
               w_cnt_nxt         = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt       = ST_IDLE;
            w_grant_nxt       = '0;
            w_grant_valid_nxt = 1'b0;
            w_cnt_nxt         = '0;
         end
      endcase
   end

   // State and registered outputs; reset clears everything asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_grant       <= '0;
         r_grant_id    <= '0;
         r_grant_valid <= 1'b0;
         r_timeout     <= 1'b0;
         r_last        <= '0;
         r_cnt         <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_grant       <= w_grant_nxt;
         r_grant_id    <= w_grant_id_nxt;
         r_grant_valid <= w_grant_valid_nxt;
         r_timeout     <= w_timeout_nxt;
         r_last        <= w_last_nxt;
         r_cnt         <= w_cnt_nxt;
      end
   end

   assign grant       = r_grant;
   assign grant_id    = r_grant_id;
   assign grant_valid = r_grant_valid;
   assign timeout     = r_timeout;

endmodule : rr_arbiter

// File: tb/tb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter
// Purpose : self-checking bench for rr_arbiter (N=8, TIMEOUT=16). Directed
//           scenarios plus a randomized run against a transaction-level
//           model that tracks the current owner and how long it has held.
// ---------------------------------------------------------------------------
module tb_rr_arbiter;

   localparam int N       = 8;
   localparam int M       = 3;
   localparam int TIMEOUT = 16;

   logic         clk;
   logic         rst;
   logic [N-1:0] req;
   logic         done;
   logic [N-1:0] grant;
   logic [M-1:0] grant_id;
   logic         grant_valid;
   logic         timeout;

   int n_checks;
   int n_fail;

   // Model: owner index (-1 = nobody), previous winner, cycles held so far.
   int m_owner;
   int m_last;
   int m_held;
   bit m_to;

   rr_arbiter #(.N(N), .M(M), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_id    (grant_id),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int pick_winner(input logic [N-1:0] r, input int last);
      for (int i = last - 1; i >= 0; i--)
         if (r[i]) return i;
      for (int i = N - 1; i >= 0; i--)
         if (r[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_last  = 0;
      m_held  = 0;
      m_to    = 1'b0;
   endtask

   // One clock of the reference: what the arbiter decides at this edge.
   task automatic model_edge(input logic [N-1:0] r, input logic d);
      m_to = 1'b0;
      if (m_owner < 0) begin
         if (r != '0) begin
            m_owner = pick_winner(r, m_last);
            m_last  = m_owner;
            m_held  = 1;
         end
      end else if (d || !r[m_owner]) begin
         m_owner = -1;
      end else if (m_held == TIMEOUT) begin
         m_owner = -1;
         m_to    = 1'b1;
      end else begin
         m_held++;
      end
   endtask

   function automatic logic [N-1:0] exp_grant();
      return (m_owner >= 0) ? (N'(1) << m_owner) : '0;
   endfunction

   // Drive inputs, let one edge pass, step the model, settle past the edge.
   task automatic cycle(input logic [N-1:0] r, input logic d);
      req  = r;
      done = d;
      @(posedge clk);
      model_edge(r, d);
      #1;
   endtask

   task automatic go_idle();
      cycle('0, 1'b0);
      cycle('0, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '0; done = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({grant, grant_id, grant_valid, timeout} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got grant=%b id=%0d valid=%b to=%b, want all zero",
                  grant, grant_id, grant_valid, timeout);
      end
      @(negedge clk);
      rst = 1'b0;
      cycle('0, 1'b1);
      n_checks++;
      if (grant_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL done_in_idle: got valid=%b, want 0", grant_valid);
      end
   endtask

   task automatic test_first_grant();
      cycle(8'b0010_0100, 1'b0);
      n_checks++;
      if (grant !== 8'b0010_0000 || grant_id !== 3'd5 || grant_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL first_grant: got grant=%b id=%0d valid=%b, want 00100000 5 1",
                  grant, grant_id, grant_valid);
      end
   endtask

   task automatic test_rotation();
      cycle(8'b0010_0100, 1'b1);
      n_checks++;
      if (grant !== '0 || grant_valid !== 1'b0 || timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL done_release: got grant=%b valid=%b to=%b, want 0 0 0",
                  grant, grant_valid, timeout);
      end
      cycle(8'b0010_0100, 1'b0);
      n_checks++;
      if (grant_id !== 3'd2 || grant !== 8'b0000_0100 || grant_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rotate_down: got id=%0d grant=%b valid=%b, want 2 00000100 1",
                  grant_id, grant, grant_valid);
      end
      cycle(8'b0010_0100, 1'b1);
      cycle(8'b0010_0100, 1'b0);
      n_checks++;
      if (grant_id !== 3'd5 || grant_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rotate_wrap: got id=%0d valid=%b, want 5 1", grant_id, grant_valid);
      end
   endtask

   task automatic test_timeout();
      int busy;
      bit dropped;
      go_idle();
      cycle(8'h08, 1'b0);
      busy = (grant_valid === 1'b1) ? 1 : 0;
      dropped = 1'b0;
      for (int k = 0; k < 40 && !dropped; k++) begin
         cycle(8'h08, 1'b0);
         if (grant_valid === 1'b1) begin
            busy++;
         end else begin
            dropped = 1'b1;
         end
      end
      n_checks++;
      if (!dropped || busy != TIMEOUT) begin
         n_fail++;
         $display("FAIL timeout_hold: got %0d busy cycles (dropped=%0d), want %0d",
                  busy, dropped, TIMEOUT);
      end
      n_checks++;
      if (timeout !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_pulse: got timeout=%b at drop, want 1", timeout);
      end
      cycle(8'h08, 1'b0);
      n_checks++;
      if (timeout !== 1'b0 || grant_valid !== 1'b1 || grant_id !== 3'd3) begin
         n_fail++;
         $display("FAIL timeout_regrant: got to=%b valid=%b id=%0d, want 0 1 3",
                  timeout, grant_valid, grant_id);
      end
   endtask

   task automatic test_req_drop();
      go_idle();
      cycle(8'h10, 1'b0);
      cycle(8'h10, 1'b0);
      cycle(8'h10, 1'b0);
      cycle(8'h00, 1'b0);
      n_checks++;
      if (grant_valid !== 1'b0 || timeout !== 1'b0 || grant !== '0) begin
         n_fail++;
         $display("FAIL req_drop: got valid=%b to=%b grant=%b, want 0 0 0",
                  grant_valid, timeout, grant);
      end
   endtask

   task automatic test_done_at_limit();
      go_idle();
      cycle(8'h02, 1'b0);
      for (int k = 1; k < TIMEOUT; k++) cycle(8'h82, 1'b0);
      n_checks++;
      if (grant_valid !== 1'b1 || grant_id !== 3'd1) begin
         n_fail++;
         $display("FAIL limit_hold: got valid=%b id=%0d in last cycle, want 1 1",
                  grant_valid, grant_id);
      end
      cycle(8'h82, 1'b1);
      n_checks++;
      if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL done_beats_timeout: got valid=%b to=%b, want 0 0",
                  grant_valid, timeout);
      end
   endtask

   task automatic test_reset_mid_grant();
      go_idle();
      cycle(8'h40, 1'b0);
      cycle(8'h40, 1'b0);
      n_checks++;
      if (grant_id !== 3'd6 || grant_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_grant: got id=%0d valid=%b, want 6 1", grant_id, grant_valid);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({grant, grant_id, grant_valid, timeout} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got grant=%b id=%0d valid=%b to=%b, want all zero",
                  grant, grant_id, grant_valid, timeout);
      end
      req = 8'b0100_0001;
      @(posedge clk);
      #2 rst = 1'b0;
      model_reset();
      cycle(8'b0100_0001, 1'b0);
      n_checks++;
      if (grant_id !== 3'd6 || grant !== 8'b0100_0000 || timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_grant: got id=%0d grant=%b to=%b, want 6 01000000 0",
                  grant_id, grant, timeout);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] r;
      logic         d;
      r = '0;
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 5) == 0) r = N'($urandom_range(0, 255));
         d = ($urandom_range(0, 9) == 0);
         cycle(r, d);
         n_checks++;
         if (grant !== exp_grant() || grant_valid !== (m_owner >= 0) || timeout !== m_to ||
             (m_owner >= 0 && grant_id !== M'(m_owner))) begin
            n_fail++;
            $display("FAIL random_cycle%0d: got grant=%b id=%0d valid=%b to=%b, want grant=%b owner=%0d to=%b",
                     k, grant, grant_id, grant_valid, timeout, exp_grant(), m_owner, m_to);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_first_grant();
      test_rotation();
      test_timeout();
      test_req_drop();
      test_done_at_limit();
      test_reset_mid_grant();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_rr_arbiter
